riscv_pipe_stage: RTL and testbench
===================================

Name: riscv_pipe_stage

Overview:
- Generic, parametrised pipeline-stage register for the RV32I core (IF/ID, ID/EX, EX/MEM, MEM/WB boundaries).
- Replaces the fixed per-field stage registers with one packed payload plus valid/ready flow control, synchronous flush, and an optional 2-entry skid buffer.
- The skid buffer breaks the combinational ready path between stages.
- Stage-specific field packing is done by the instantiating stage.

Parameters:
- PAYLOAD_W, 32: width of the packed stage payload in bits; range 1..512.
- RESET_VAL, 0: value loaded into every payload storage bit on reset or flush; zero-extended or truncated to PAYLOAD_W.
- SKID, 1: 0 = single register with pass-through ready; 1 = two-entry skid buffer with registered ready.

Ports:
- i_clk  in  1  stage clock
- i_rstn  in  1  asynchronous active-low reset
- i_clr  in  1  synchronous flush (branch mispredict / trap); bubbles the stage
- i_up_valid  in  1  upstream payload valid
- o_up_ready  out  1  stage can accept payload this cycle
- i_up_data  in  PAYLOAD_W  upstream payload
- o_dn_valid  out  1  downstream payload valid
- i_dn_ready  in  1  downstream accepts payload (low = stall)
- o_dn_data  out  PAYLOAD_W  downstream payload
- o_occupancy  out  2  number of held entries (0..2)

Behaviour:
- Reset is asynchronous and active-low: i_rstn low forces the following immediately, independent of i_clk:
  - o_dn_valid = 0, o_occupancy = 0;
  - all payload storage = RESET_VAL, so o_dn_data = RESET_VAL;
  - o_up_ready = 1.
- Fire definitions: up_fire = i_up_valid & o_up_ready; dn_fire = o_dn_valid & i_dn_ready.
- Latency: 1 cycle. Data accepted on edge N is on o_dn_data after edge N; there is no bypass path from i_up_data to o_dn_data.
- SKID=0:
  - o_up_ready = ~o_dn_valid | i_dn_ready (combinational).
  - Main register loads on up_fire.
  - o_dn_valid next = up_fire | (o_dn_valid & ~i_dn_ready).
  - o_occupancy is 0 or 1.
- SKID=1 uses a state machine with states EMPTY, BUSY and FULL:
  - o_up_ready is a flop, equal to (state != FULL).
  - o_dn_valid = (state != EMPTY); o_dn_data = main register.
  - EMPTY: up_fire -> BUSY, main <= i_up_data.
  - BUSY, up_fire & dn_fire -> BUSY, main <= i_up_data.
  - BUSY, up_fire & ~dn_fire -> FULL, skid <= i_up_data.
  - BUSY, ~up_fire & dn_fire -> EMPTY.
  - BUSY, no fire -> hold.
  - FULL: dn_fire -> BUSY, main <= skid. No up_fire is possible because ready = 0.
  - FULL, ~dn_fire -> hold; main and skid are stable for the whole stall.
  - o_occupancy: EMPTY = 0, BUSY = 1, FULL = 2.
- Ordering: payloads exit in the order they were accepted. No drop and no duplication in any state.
- Stall: while i_dn_ready = 0, o_dn_data and o_dn_valid hold unchanged (stability rule).
- Flush (i_clr = 1 at an edge):
  - has priority over every transition;
  - next state = EMPTY, o_dn_valid = 0, o_up_ready = 1;
  - main and skid registers = RESET_VAL;
  - an up_fire in the same cycle is discarded;
  - a dn_fire in the same cycle still counts as consumed by downstream.
- Clock gating of data: payload registers load only on their load condition (or flush/reset). The encoding of the unused skid register is don't-care except after flush/reset, where it is RESET_VAL.
- Reset asserted mid-stall in FULL: both entries are lost, outputs go to reset values asynchronously, and the stage restarts EMPTY after release.
- Illegal state encodings recover to EMPTY on the next edge.

Decomposition:
- Shared header riscv_pipe_defs.v:
  - state encodings PIPE_EMPTY = 2'd0, PIPE_BUSY = 2'd1, PIPE_FULL = 2'd2;
  - occupancy width constant;
  - stage payload width constants built from `XLEN (included alongside riscv_configs.v).
- One sub-module, riscv_pipe_skid_slot: a PAYLOAD_W register with load enable, synchronous clear to RESET_VAL, and asynchronous active-low reset.
  - Instantiated once for main, plus once for skid when SKID=1 (generate).

Test Plan (PAYLOAD_W=32, RESET_VAL=0, both SKID values unless noted):
- Reset check: hold i_rstn low mid-clock with i_up_valid=1 -> o_dn_valid=0, o_dn_data=0x00000000, o_up_ready=1, o_occupancy=0, all asynchronously without a clock edge.
- Streaming: i_dn_ready=1, push 0x11,0x22,0x33 on consecutive edges -> o_dn_data shows 0x11,0x22,0x33 one cycle later; o_up_ready stays 1; occupancy stays 1.
- Stall fill (SKID=1): i_dn_ready=0, push 0xA0 then 0xB0 -> occupancy 2 and o_up_ready=0; a third push of 0xC0 is not accepted. Release i_dn_ready -> outputs 0xA0, then 0xB0, then 0xC0 (accepted once ready=1), with no loss.
- Stall hold (SKID=0): i_dn_ready=0 for 5 cycles after pushing 0x55 -> o_dn_data=0x55 and o_dn_valid=1 stable; o_up_ready=0 throughout.
- Flush: state FULL with 0xA0/0xB0, assert i_clr with i_up_valid=1 and data 0xDD -> next cycle o_dn_valid=0, occupancy 0, o_dn_data=0. 0xDD never appears downstream.
- Random back-pressure: 10k cycles of random valid/ready -> scoreboard confirms in-order, lossless delivery, and o_occupancy matches the count of accepted minus delivered payloads.

Source files
------------

// File: rtl/riscv_pipe_stage_pkg.sv
// Shared definitions for the RV32I pipeline-stage registers: state encodings,
// occupancy width and per-boundary payload widths.
package riscv_pipe_stage_pkg;

    localparam int XLEN  = 32;
    localparam int OCC_W = 2;

    // Payload widths the stages pack into a riscv_pipe_stage instance
    localparam int IF_ID_W  = 2 * XLEN;
    localparam int ID_EX_W  = 4 * XLEN + 16;
    localparam int EX_MEM_W = 2 * XLEN + 12;
    localparam int MEM_WB_W = XLEN + 6;

    typedef enum logic [1:0] {
        PIPE_EMPTY = 2'd0,
        PIPE_BUSY  = 2'd1,
        PIPE_FULL  = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/riscv_pipe_skid_slot.sv
// One payload register of a pipeline stage: load enable, synchronous clear
// to the reset value, asynchronous active-low reset.
module riscv_pipe_skid_slot #(
    parameter int             W         = 32,
    parameter logic [W-1:0]   RESET_VAL = '0
) (
    input  logic         i_clk,
    input  logic         i_rstn,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] q_reg;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn)
            q_reg <= RESET_VAL;
        else if (i_clr)
            q_reg <= RESET_VAL;
        else if (i_load)
            q_reg <= i_d;
    end

    assign o_q = q_reg;

endmodule

// File: rtl/riscv_pipe_stage.sv
// Generic valid/ready pipeline-stage register with flush and an optional
// two-entry skid buffer that registers the upstream ready.
module riscv_pipe_stage
    import riscv_pipe_stage_pkg::*;
#(
    parameter int           PAYLOAD_W = 32,
    parameter logic [511:0] RESET_VAL = '0,
    parameter int           SKID      = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic                 i_clr,
    input  logic                 i_up_valid,
    output logic                 o_up_ready,
    input  logic [PAYLOAD_W-1:0] i_up_data,
    output logic                 o_dn_valid,
    input  logic                 i_dn_ready,
    output logic [PAYLOAD_W-1:0] o_dn_data,
    output logic [OCC_W-1:0]     o_occupancy
);

    localparam logic [PAYLOAD_W-1:0] RST_VAL = RESET_VAL[PAYLOAD_W-1:0];

    generate
        if (SKID == 0) begin : g_single
            logic valid_reg;
            logic up_fire;

            // Ready passes straight through from downstream
            assign o_up_ready = ~valid_reg | i_dn_ready;
            assign up_fire    = i_up_valid & o_up_ready;

            always_ff @(posedge i_clk or negedge i_rstn) begin
                if (!i_rstn)
                    valid_reg <= 1'b0;
                else if (i_clr)
                    valid_reg <= 1'b0;
                else
                    valid_reg <= up_fire | (valid_reg & ~i_dn_ready);
            end

            riscv_pipe_skid_slot #(.W(PAYLOAD_W), .RESET_VAL(RST_VAL)) u_main (
                .i_clk  (i_clk),
                .i_rstn (i_rstn),
                .i_clr  (i_clr),
                .i_load (up_fire),
                .i_d    (i_up_data),
                .o_q    (o_dn_data)
            );

            assign o_dn_valid  = valid_reg;
            assign o_occupancy = OCC_W'(valid_reg);
        end else begin : g_skid
            pipe_state_e          state_reg;
            pipe_state_e          state_next;
            logic                 ready_reg;
            logic                 up_fire;
            logic                 dn_fire;
            logic                 main_load;
            logic                 skid_load;
            logic [PAYLOAD_W-1:0] main_d;
            logic [PAYLOAD_W-1:0] skid_q;

            assign o_up_ready = ready_reg;
            assign o_dn_valid = (state_reg != PIPE_EMPTY);
            assign up_fire    = i_up_valid & ready_reg;
            assign dn_fire    = o_dn_valid & i_dn_ready;

            always_comb begin
                state_next = state_reg;
                main_load  = 1'b0;
                skid_load  = 1'b0;
                main_d     = i_up_data;
                if (i_clr) begin
                    state_next = PIPE_EMPTY;
                end else begin
                    case (state_reg)
                        PIPE_EMPTY: begin
                            if (up_fire) begin
                                state_next = PIPE_BUSY;
                                main_load  = 1'b1;
                            end
                        end
                        PIPE_BUSY: begin
                            if (up_fire && dn_fire) begin
                                main_load = 1'b1;
                            end else if (up_fire) begin
                                state_next = PIPE_FULL;
                                skid_load  = 1'b1;
                            end else if (dn_fire) begin
                                state_next = PIPE_EMPTY;
                            end
                        end
                        PIPE_FULL: begin
                            // Ready is low here, so only the drain can happen
                            if (dn_fire) begin
                                state_next = PIPE_BUSY;
                                main_load  = 1'b1;
                                main_d     = skid_q;
                            end
                        end
                        default: state_next = PIPE_EMPTY;
                    endcase
                end
            end

            always_ff @(posedge i_clk or negedge i_rstn) begin
                if (!i_rstn) begin
                    state_reg <= PIPE_EMPTY;
                    ready_reg <= 1'b1;
                end else begin
                    state_reg <= state_next;
                    ready_reg <= (state_next != PIPE_FULL);
                end
            end

            riscv_pipe_skid_slot #(.W(PAYLOAD_W), .RESET_VAL(RST_VAL)) u_main (
                .i_clk  (i_clk),
                .i_rstn (i_rstn),
                .i_clr  (i_clr),
                .i_load (main_load),
                .i_d    (main_d),
                .o_q    (o_dn_data)
            );

            riscv_pipe_skid_slot #(.W(PAYLOAD_W), .RESET_VAL(RST_VAL)) u_skid (
                .i_clk  (i_clk),
                .i_rstn (i_rstn),
                .i_clr  (i_clr),
                .i_load (skid_load),
                .i_d    (i_up_data),
                .o_q    (skid_q)
            );

            always_comb begin
                case (state_reg)
                    PIPE_BUSY: o_occupancy = OCC_W'(1);
                    PIPE_FULL: o_occupancy = OCC_W'(2);
                    default:   o_occupancy = OCC_W'(0);
                endcase
            end
        end
    endgenerate

endmodule

// File: tb/tb_riscv_pipe_stage.sv
// Directed and random back-pressure checks of riscv_pipe_stage, one instance
// per SKID setting driven from a shared clock, reset, flush and ready.
module tb_riscv_pipe_stage;

    logic        clk;
    logic        rstn;
    logic        clr;
    logic        dr;
    logic        uv0, uv1;
    logic [31:0] ud0, ud1;
    logic        ur0, ur1;
    logic        dv0, dv1;
    logic [31:0] dd0, dd1;
    logic [1:0]  oc0, oc1;

    int tests;
    int fails;

    logic [31:0] q0[$];
    logic [31:0] q1[$];

    riscv_pipe_stage #(.PAYLOAD_W(32), .RESET_VAL('0), .SKID(0)) d0 (
        .i_clk(clk), .i_rstn(rstn), .i_clr(clr),
        .i_up_valid(uv0), .o_up_ready(ur0), .i_up_data(ud0),
        .o_dn_valid(dv0), .i_dn_ready(dr), .o_dn_data(dd0),
        .o_occupancy(oc0)
    );

    riscv_pipe_stage #(.PAYLOAD_W(32), .RESET_VAL('0), .SKID(1)) d1 (
        .i_clk(clk), .i_rstn(rstn), .i_clr(clr),
        .i_up_valid(uv1), .o_up_ready(ur1), .i_up_data(ud1),
        .o_dn_valid(dv1), .i_dn_ready(dr), .o_dn_data(dd1),
        .o_occupancy(oc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk0(input string tag, input logic v, input logic [31:0] d,
                        input logic r, input logic [1:0] o);
        chk({tag, "/s0 valid"}, {31'd0, dv0}, {31'd0, v});
        chk({tag, "/s0 data"},  dd0, d);
        chk({tag, "/s0 ready"}, {31'd0, ur0}, {31'd0, r});
        chk({tag, "/s0 occ"},   {30'd0, oc0}, {30'd0, o});
    endtask

    task automatic chk1(input string tag, input logic v, input logic [31:0] d,
                        input logic r, input logic [1:0] o);
        chk({tag, "/s1 valid"}, {31'd0, dv1}, {31'd0, v});
        chk({tag, "/s1 data"},  dd1, d);
        chk({tag, "/s1 ready"}, {31'd0, ur1}, {31'd0, r});
        chk({tag, "/s1 occ"},   {30'd0, oc1}, {30'd0, o});
    endtask

    initial begin
        logic        uf0, uf1, df0, df1;
        logic [31:0] seq0, seq1;
        tests = 0;
        fails = 0;
        rstn = 1'b0; clr = 1'b0; dr = 1'b1;
        uv0 = 1'b0; uv1 = 1'b0; ud0 = '0; ud1 = '0;

        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        step();
        chk0("reset", 1'b0, 32'h0, 1'b1, 2'd0);
        chk1("reset", 1'b0, 32'h0, 1'b1, 2'd0);

        // Streaming at full rate
        dr = 1'b1; uv0 = 1'b1; uv1 = 1'b1;
        ud0 = 32'h11; ud1 = 32'h11; step();
        chk0("stream11", 1'b1, 32'h11, 1'b1, 2'd1);
        chk1("stream11", 1'b1, 32'h11, 1'b1, 2'd1);
        ud0 = 32'h22; ud1 = 32'h22; step();
        chk0("stream22", 1'b1, 32'h22, 1'b1, 2'd1);
        chk1("stream22", 1'b1, 32'h22, 1'b1, 2'd1);
        ud0 = 32'h33; ud1 = 32'h33; step();
        chk0("stream33", 1'b1, 32'h33, 1'b1, 2'd1);
        chk1("stream33", 1'b1, 32'h33, 1'b1, 2'd1);
        uv0 = 1'b0; uv1 = 1'b0; step();
        chk0("drain", 1'b0, 32'h33, 1'b1, 2'd0);
        chk1("drain", 1'b0, 32'h33, 1'b1, 2'd0);

        // Stall: SKID=0 holds one entry, SKID=1 fills to two
        dr = 1'b0; uv0 = 1'b1; uv1 = 1'b1;
        ud0 = 32'hA0; ud1 = 32'hA0; step();
        chk0("stallA0", 1'b1, 32'hA0, 1'b0, 2'd1);
        chk1("stallA0", 1'b1, 32'hA0, 1'b1, 2'd1);
        ud0 = 32'hB0; ud1 = 32'hB0; step();
        chk0("stallB0", 1'b1, 32'hA0, 1'b0, 2'd1);
        chk1("stallB0", 1'b1, 32'hA0, 1'b0, 2'd2);
        ud0 = 32'hC0; ud1 = 32'hC0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk0("stallhold", 1'b1, 32'hA0, 1'b0, 2'd1);
            chk1("stallhold", 1'b1, 32'hA0, 1'b0, 2'd2);
        end
        dr = 1'b1; step();
        chk0("releaseC0", 1'b1, 32'hC0, 1'b1, 2'd1);
        chk1("releaseB0", 1'b1, 32'hB0, 1'b1, 2'd1);
        uv0 = 1'b0; step();
        chk0("release2", 1'b0, 32'hC0, 1'b1, 2'd0);
        chk1("releaseC0", 1'b1, 32'hC0, 1'b1, 2'd1);
        uv1 = 1'b0; step();
        chk1("releaseEnd", 1'b0, 32'hC0, 1'b1, 2'd0);

        // Flush from FULL with a coincident push that must be discarded
        dr = 1'b0; uv1 = 1'b1; ud1 = 32'hA0; uv0 = 1'b1; ud0 = 32'h55; step();
        uv0 = 1'b0; ud1 = 32'hB0; step();
        chk1("preflush", 1'b1, 32'hA0, 1'b0, 2'd2);
        chk0("preflush", 1'b1, 32'h55, 1'b0, 2'd1);
        clr = 1'b1; uv0 = 1'b1; ud0 = 32'hDD; ud1 = 32'hDD; step();
        chk0("flush", 1'b0, 32'h0, 1'b1, 2'd0);
        chk1("flush", 1'b0, 32'h0, 1'b1, 2'd0);
        clr = 1'b0; uv0 = 1'b0; uv1 = 1'b0; dr = 1'b1; step();
        chk0("postflush", 1'b0, 32'h0, 1'b1, 2'd0);
        chk1("postflush", 1'b0, 32'h0, 1'b1, 2'd0);

        // Asynchronous reset in the middle of a FULL stall
        dr = 1'b0; uv1 = 1'b1; ud1 = 32'hA0; uv0 = 1'b1; ud0 = 32'h55; step();
        ud1 = 32'hB0; step();
        chk1("prereset", 1'b1, 32'hA0, 1'b0, 2'd2);
        rstn = 1'b0;
        #2;
        chk0("asyncreset", 1'b0, 32'h0, 1'b1, 2'd0);
        chk1("asyncreset", 1'b0, 32'h0, 1'b1, 2'd0);
        step();
        rstn = 1'b1; uv0 = 1'b0; uv1 = 1'b0; dr = 1'b1; step();
        chk0("postreset", 1'b0, 32'h0, 1'b1, 2'd0);
        chk1("postreset", 1'b0, 32'h0, 1'b1, 2'd0);

        // Random valid/ready against an in-order scoreboard per instance
        seq0 = 32'h1000_0000;
        seq1 = 32'h2000_0000;
        for (int c = 0; c < 10000; c++) begin
            uv0 = ($urandom_range(0, 3) != 0);
            uv1 = ($urandom_range(0, 3) != 0);
            dr  = ($urandom_range(0, 2) != 0);
            ud0 = seq0;
            ud1 = seq1;
            #1;
            chk("rnd/s0 valid", {31'd0, dv0}, {31'd0, (q0.size() != 0)});
            chk("rnd/s0 occ", {30'd0, oc0}, 32'(q0.size()));
            if (q0.size() != 0) chk("rnd/s0 data", dd0, q0[0]);
            chk("rnd/s1 valid", {31'd0, dv1}, {31'd0, (q1.size() != 0)});
            chk("rnd/s1 occ", {30'd0, oc1}, 32'(q1.size()));
            chk("rnd/s1 ready", {31'd0, ur1}, {31'd0, (q1.size() < 2)});
            if (q1.size() != 0) chk("rnd/s1 data", dd1, q1[0]);
            uf0 = uv0 & ur0;
            df0 = dv0 & dr;
            uf1 = uv1 & ur1;
            df1 = dv1 & dr;
            if (df0 && q0.size() != 0) void'(q0.pop_front());
            if (uf0) begin q0.push_back(seq0); seq0++; end
            if (df1 && q1.size() != 0) void'(q1.pop_front());
            if (uf1) begin q1.push_back(seq1); seq1++; end
            @(posedge clk);
            #1;
        end
        chk("rnd/s0 moved", {31'd0, (seq0 > 32'h1000_1000)}, 32'd1);
        chk("rnd/s1 moved", {31'd0, (seq1 > 32'h2000_1000)}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
